// File: rtl/mme_rd_dma.sv
// mme_rd_dma: read-side DMA for the matrix-multiply engine.
// For each step k it fetches column k of A and row k of B as two 4-beat INCR
// bursts, then presents the pair to the MAC array on a valid/ready handshake.
module mme_rd_dma #(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter int         CNT_W  = 16,
    parameter logic [3:0] ID     = 4'd0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      mat_width,
    input  logic [ADDR_W-1:0]     mat_a_addr,
    input  logic [ADDR_W-1:0]     mat_b_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_W-1:0]     araddr,
    output logic [3:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [3:0]            arid,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [4*DATA_W-1:0]   a_col,
    output logic [4*DATA_W-1:0]   b_row,
    output logic                  pair_valid,
    input  logic                  pair_ready,
    output logic                  pair_last
);

    typedef enum logic [2:0] {IDLE, REQ_A, DAT_A, REQ_B, DAT_B, OUT} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_width;
    logic [CNT_W-1:0]     r_k;
    logic [ADDR_W-1:0]    r_a_base;
    logic [ADDR_W-1:0]    r_b_base;
    logic [1:0]           r_beat;
    logic                 r_arvalid;
    logic [ADDR_W-1:0]    r_araddr;
    logic [4*DATA_W-1:0]  r_a_col;
    logic [4*DATA_W-1:0]  r_b_row;
    logic                 r_done;
    logic                 r_err;

    logic                 w_start_ok;
    logic                 w_beat_ok;
    logic                 w_burst_end;
    logic                 w_pair_ok;
    logic                 w_last;
    logic                 w_beat_err;
    logic [CNT_W-1:0]     w_width_m1;
    logic [ADDR_W-1:0]    w_koff;

    // Byte offset of step k: each column/row is four 32-bit words.
    assign w_koff     = ADDR_W'(r_k) << 4;
    assign w_width_m1 = r_width - CNT_W'(1);
    assign w_last     = (r_k == w_width_m1);

    // A beat is bad if it reports an error or its rlast disagrees with its position.
    assign w_beat_err = (rresp != 2'b00)
                      | ((r_beat != 2'd3) & rlast)
                      | ((r_beat == 2'd3) & ~rlast);

    assign arlen      = 4'd3;
    assign arsize     = 3'd2;
    assign arburst    = 2'b01;
    assign arid       = ID;
    assign arvalid    = r_arvalid;
    assign araddr     = r_araddr;
    assign rready     = (r_state == DAT_A) || (r_state == DAT_B);
    assign pair_valid = (r_state == OUT);
    assign pair_last  = (r_state == OUT) && w_last;
    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign err        = r_err;
    assign a_col      = r_a_col;
    assign b_row      = r_b_row;

    // State register; reset aborts any transfer immediately.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle event strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_beat_ok   = 1'b0;
        w_burst_end = 1'b0;
        w_pair_ok   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start_ok = 1'b1;
                    if (mat_width != '0) begin
                        w_state_nxt = REQ_A;
                    end
                end
            end
            REQ_A: begin
                if (r_arvalid && arready) begin
                    w_state_nxt = DAT_A;
                end
            end
            DAT_A: begin
                if (rvalid) begin
                    w_beat_ok = 1'b1;
                    if (r_beat == 2'd3) begin
                        w_burst_end = 1'b1;
                        w_state_nxt = REQ_B;
                    end
                end
            end
            REQ_B: begin
                if (r_arvalid && arready) begin
                    w_state_nxt = DAT_B;
                end
            end
            DAT_B: begin
                if (rvalid) begin
                    w_beat_ok = 1'b1;
                    if (r_beat == 2'd3) begin
                        w_burst_end = 1'b1;
                        w_state_nxt = OUT;
                    end
                end
            end
            OUT: begin
                if (pair_ready) begin
                    w_pair_ok   = 1'b1;
                    w_state_nxt = w_last ? IDLE : REQ_A;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Job registers, AR request, beat capture, done pulse and sticky error.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_width   <= '0;
            r_k       <= '0;
            r_a_base  <= '0;
            r_b_base  <= '0;
            r_beat    <= '0;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_a_col   <= '0;
            r_b_row   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_ok) begin
                r_width  <= mat_width;
                r_a_base <= mat_a_addr;
                r_b_base <= mat_b_addr;
                r_k      <= '0;
                r_beat   <= '0;
                r_err    <= 1'b0;
                if (mat_width == '0) begin
                    r_done <= 1'b1;
                end else begin
                    // First A request goes out straight from IDLE: k is 0.
                    r_arvalid <= 1'b1;
                    r_araddr  <= mat_a_addr;
                end
            end
            // Later A requests spend one entry cycle forming the address from the new k.
            if ((r_state == REQ_A) && !r_arvalid) begin
                r_arvalid <= 1'b1;
                r_araddr  <= r_a_base + w_koff;
            end
            if (r_arvalid && arready) begin
                r_arvalid <= 1'b0;
            end
            if (w_beat_ok) begin
                r_beat <= r_beat + 2'd1;
                for (int j = 0; j < 4; j++) begin
                    if (r_beat == 2'(j)) begin
                        if (r_state == DAT_A) begin
                            r_a_col[j*DATA_W +: DATA_W] <= rdata;
                        end else begin
                            r_b_row[j*DATA_W +: DATA_W] <= rdata;
                        end
                    end
                end
                if (w_beat_err) begin
                    r_err <= 1'b1;
                end
            end
            // B request is raised together with the move into REQ_B.
            if (w_burst_end && (r_state == DAT_A)) begin
                r_arvalid <= 1'b1;
                r_araddr  <= r_b_base + w_koff;
            end
            if (w_pair_ok) begin
                if (w_last) begin
                    r_done <= 1'b1;
                end else begin
                    r_k <= r_k + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mme_rd_dma.sv
// Self-checking bench for mme_rd_dma: randomised AXI memory and MAC-side stalls,
// with a transaction-level model of expected bursts, pairs, busy/done/err.
`timescale 1ns/1ps
module tb_mme_rd_dma;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [15:0]   mat_width;
    logic [31:0]   mat_a_addr;
    logic [31:0]   mat_b_addr;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   araddr;
    logic [3:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [3:0]    arid;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;
    logic [127:0]  a_col;
    logic [127:0]  b_row;
    logic          pair_valid;
    logic          pair_ready;
    logic          pair_last;

    mme_rd_dma #(.ADDR_W(32), .DATA_W(32), .CNT_W(16), .ID(4'd0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mat_width(mat_width),
        .mat_a_addr(mat_a_addr), .mat_b_addr(mat_b_addr), .busy(busy), .done(done),
        .err(err), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arid(arid), .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready), .a_col(a_col), .b_row(b_row),
        .pair_valid(pair_valid), .pair_ready(pair_ready), .pair_last(pair_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Memory contents: a fixed scramble of the byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    // ---------------- stimulus knobs ----------------
    logic          stall_mode = 1'b0;
    logic          inj_on = 1'b0;
    logic [31:0]   inj_resp_addr = '0;
    int            inj_resp_beat = 0;
    logic [31:0]   inj_rlast_addr = '0;
    int            inj_rlast_beat = 0;

    function automatic int stall();
        return stall_mode ? int'($urandom_range(0, 5)) : 0;
    endfunction

    // ---------------- AXI read slave and MAC-side ready ----------------
    int           s_phase, s_beat, s_wait, s_arwait, pr_hold;
    logic [31:0]  s_addr;

    initial begin
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; pair_ready = 1'b1;
        s_phase = 0; s_beat = 0; s_wait = 0; s_arwait = 0; pr_hold = 0; s_addr = '0;
        forever begin
            @(negedge clk);
            if (pr_hold > 0) begin
                pair_ready = 1'b0;
                pr_hold--;
            end else begin
                pair_ready = 1'b1;
                if (stall_mode && $urandom_range(0, 1) == 1) pr_hold = int'($urandom_range(1, 5));
            end
            if (rst_n) begin
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = '0;
                s_phase = 0; s_wait = 0; s_arwait = 0;
            end else if (s_phase == 0) begin
                rvalid = 1'b0; rlast = 1'b0; rresp = '0;
                if (arvalid && s_arwait == 0) begin
                    arready = 1'b1;
                    s_addr = araddr; s_phase = 1; s_beat = 0;
                    s_wait = stall(); s_arwait = stall();
                end else begin
                    arready = 1'b0;
                    if (arvalid) s_arwait--;
                end
            end else begin
                arready = 1'b0;
                if (s_wait > 0) begin
                    rvalid = 1'b0; rlast = 1'b0; rresp = '0;
                    s_wait--;
                end else begin
                    rvalid = 1'b1;
                    rdata  = mem_word(s_addr + 32'(4 * s_beat));
                    rresp  = (inj_on && s_addr == inj_resp_addr && s_beat == inj_resp_beat) ? 2'b10 : 2'b00;
                    rlast  = (s_beat == 3) || (inj_on && s_addr == inj_rlast_addr && s_beat == inj_rlast_beat);
                    s_beat++;
                    s_wait = stall();
                    if (s_beat == 4) s_phase = 0;
                end
            end
        end
    end

    // ---------------- reference model and per-cycle compare ----------------
    typedef struct packed {
        logic [127:0] a;
        logic [127:0] b;
        logic         last;
    } pair_t;

    pair_t        exp_pairs[$];
    logic [31:0]  exp_ar[$];
    logic [31:0]  ar_log[$];
    int           pairs_seen, done_cnt, m_beat;
    logic         e_busy, e_done, e_err, n_busy, n_done, n_err;
    logic         prev_ar_pend, prev_pv_pend;
    logic [31:0]  m_first_a0, m_first_b0;

    initial begin
        e_busy = 0; e_done = 0; e_err = 0; m_beat = 0; prev_ar_pend = 0; prev_pv_pend = 0;
        pairs_seen = 0; done_cnt = 0; m_first_a0 = '0; m_first_b0 = '0;
        forever begin
            @(negedge clk);
            #1;
            chk("arlen", arlen, 3);
            chk("arsize", arsize, 2);
            chk("arburst", arburst, 1);
            chk("arid", arid, 0);
            if (rst_n) begin
                chk("rst_arvalid", arvalid, 0);
                chk("rst_araddr", araddr, 0);
                chk("rst_rready", rready, 0);
                chk("rst_pair_valid", pair_valid, 0);
                chk("rst_pair_last", pair_last, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_err", err, 0);
                chk("rst_a_col", a_col, 0);
                chk("rst_b_row", b_row, 0);
                e_busy = 0; e_done = 0; e_err = 0; m_beat = 0;
                prev_ar_pend = 0; prev_pv_pend = 0;
                exp_pairs.delete(); exp_ar.delete();
            end else begin
                chk("busy", busy, e_busy);
                chk("done", done, e_done);
                chk("err", err, e_err);
                if (done) done_cnt++;
                if (prev_ar_pend) chk("arvalid_hold", arvalid, 1);
                if (prev_pv_pend) chk("pair_valid_hold", pair_valid, 1);
                n_busy = e_busy; n_done = 0; n_err = e_err;
                if (arvalid) begin
                    if (exp_ar.size() == 0) begin
                        chk("arvalid_unexpected", arvalid, 0);
                    end else begin
                        chk("araddr", araddr, exp_ar[0]);
                        if (arready) begin
                            ar_log.push_back(araddr);
                            void'(exp_ar.pop_front());
                            m_beat = 0;
                        end
                    end
                end
                if (rvalid) begin
                    chk("rready", rready, 1);
                    if (rready) begin
                        if (rresp != 2'b00 || rlast != (m_beat == 3)) n_err = 1;
                        m_beat = (m_beat + 1) % 4;
                    end
                end
                if (pair_valid) begin
                    if (exp_pairs.size() == 0) begin
                        chk("pair_unexpected", pair_valid, 0);
                    end else begin
                        chk("a_col", a_col, exp_pairs[0].a);
                        chk("b_row", b_row, exp_pairs[0].b);
                        chk("pair_last", pair_last, exp_pairs[0].last);
                        if (pair_ready) begin
                            pairs_seen++;
                            if (exp_pairs[0].last) begin
                                n_busy = 0;
                                n_done = 1;
                            end
                            void'(exp_pairs.pop_front());
                        end
                    end
                end
                if (start && !e_busy) begin
                    exp_pairs.delete(); exp_ar.delete(); ar_log.delete();
                    pairs_seen = 0; done_cnt = 0; n_err = 0;
                    m_first_a0 = mem_word(mat_a_addr);
                    m_first_b0 = mem_word(mat_b_addr);
                    for (int k = 0; k < int'(mat_width); k++) begin
                        pair_t p;
                        logic [31:0] ka, kb;
                        ka = mat_a_addr + 32'(16 * k);
                        kb = mat_b_addr + 32'(16 * k);
                        exp_ar.push_back(ka);
                        exp_ar.push_back(kb);
                        for (int r = 0; r < 4; r++) begin
                            p.a[32*r +: 32] = mem_word(ka + 32'(4 * r));
                            p.b[32*r +: 32] = mem_word(kb + 32'(4 * r));
                        end
                        p.last = (k == int'(mat_width) - 1);
                        exp_pairs.push_back(p);
                    end
                    if (mat_width == 16'd0) n_done = 1;
                    else n_busy = 1;
                end
                prev_ar_pend = arvalid && !arready;
                prev_pv_pend = pair_valid && !pair_ready;
                e_busy = n_busy; e_done = n_done; e_err = n_err;
            end
        end
    end

    // ---------------- main sequence ----------------
    task automatic pulse_start(input logic [15:0] w, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mat_width = w; mat_a_addr = a; mat_b_addr = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n;
        n = 0;
        while (!done && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", done, 1);
        @(negedge clk);
    endtask

    logic [31:0] basic_ar [8];
    int          n;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        basic_ar = '{32'h0, 32'h1000, 32'h10, 32'h1010, 32'h20, 32'h1020, 32'h30, 32'h1030};
        rst_n = 1'b1; start = 1'b0; mat_width = '0; mat_a_addr = '0; mat_b_addr = '0;
        repeat (3) @(negedge clk);
        chk("init_busy", busy, 0);
        chk("init_arvalid", arvalid, 0);
        chk("init_a_col", a_col, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Basic fetch, zero-wait memory, pair_ready tied high.
        stall_mode = 1'b0;
        @(negedge clk);
        mat_width = 16'd4; mat_a_addr = 32'h0; mat_b_addr = 32'h1000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("first_arvalid", arvalid, 1);
        chk("first_araddr", araddr, 32'h0);
        n = 1;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("basic_done_latency", n, 48);
        @(negedge clk);
        chk("basic_done_single", done, 0);
        chk("basic_burst_count", ar_log.size(), 8);
        for (int i = 0; i < 8 && i < ar_log.size(); i++) chk("basic_ar_seq", ar_log[i], basic_ar[i]);
        chk("basic_pairs", pairs_seen, 4);
        chk("basic_done_cnt", done_cnt, 1);
        chk("model_a0", m_first_a0, 32'hA5A50F0F);
        chk("model_b0", m_first_b0, 32'hD23E1F0F);

        // Zero width: done one cycle after start, no bursts, busy stays low.
        pulse_start(16'd0, 32'h40, 32'h80);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        repeat (4) @(negedge clk);
        chk("zero_bursts", ar_log.size(), 0);
        chk("zero_done_cnt", done_cnt, 1);

        // Random stalls, A base chosen so the addresses wrap past zero.
        stall_mode = 1'b1;
        pulse_start(16'd16, 32'hFFFF_FF80, 32'h2000);
        wait_done(5000);
        chk("stall_bursts", ar_log.size(), 32);
        chk("stall_pairs", pairs_seen, 16);

        // Start while busy is ignored.
        pulse_start(16'd6, 32'h100, 32'h3000);
        repeat (20) @(negedge clk);
        mat_width = 16'd3; mat_a_addr = 32'h5000; mat_b_addr = 32'h6000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3000);
        chk("busy_start_bursts", ar_log.size(), 12);
        chk("busy_start_pairs", pairs_seen, 6);
        if (ar_log.size() > 0) chk("busy_start_addr0", ar_log[0], 32'h100);

        // Bad response on k=1 B beat 2, early rlast on k=2 A beat 1.
        stall_mode = 1'b0;
        inj_on = 1'b1;
        inj_resp_addr = 32'h4010; inj_resp_beat = 2;
        inj_rlast_addr = 32'h0420; inj_rlast_beat = 1;
        pulse_start(16'd4, 32'h400, 32'h4000);
        wait_done(500);
        chk("bad_err_set", err, 1);
        chk("bad_pairs", pairs_seen, 4);
        repeat (3) @(negedge clk);
        chk("bad_err_sticky", err, 1);
        inj_on = 1'b0;
        pulse_start(16'd1, 32'h700, 32'h7000);
        chk("bad_err_cleared", err, 0);
        wait_done(200);

        // Reset during DAT_B of k=3, then a fresh width-8 job.
        stall_mode = 1'b1;
        pulse_start(16'd6, 32'h8000, 32'h9000);
        n = 0;
        while (!(ar_log.size() >= 8 && rready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_datb", (ar_log.size() >= 8 && rready), 1);
        #2;
        rst_n = 1'b1;
        #1;
        chk("async_arvalid", arvalid, 0);
        chk("async_rready", rready, 0);
        chk("async_pair_valid", pair_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        chk("async_a_col", a_col, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        pulse_start(16'd8, 32'hA000, 32'hB000);
        wait_done(5000);
        chk("after_rst_bursts", ar_log.size(), 16);
        chk("after_rst_pairs", pairs_seen, 8);
        chk("after_rst_err", err, 0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mme_rd_dma.md
# mme_rd_dma

Read-side DMA stage of the matrix-multiply engine, sitting between the APB configuration registers (matrix width, A/B base addresses, start command) and the multiply-accumulate array. For each step k = 0..width-1 it fetches column k of A (4 words, column-major) and row k of B (4 words, row-major) over the AXI read channels using one 4-beat burst per operand. It then presents the pair to the MAC array through a valid/ready handshake, and pulses `done` after the last pair is accepted.

## Interface
- `ADDR_W`, 32, AXI address width
- `DATA_W`, 32, AXI data width and element width (fixed at 32)
- `CNT_W`, 16, width of the matrix-width field
- `ID`, 0, constant ARID value
- `clk` in 1: clock, all logic on the rising edge
- `rst_n` in 1: reset, asynchronous, active-high
- `start` in 1: one-cycle start pulse from the command register
- `mat_width` in CNT_W: K dimension (A is 4xK, B is Kx4)
- `mat_a_addr` in ADDR_W: A base byte address, 16-byte aligned
- `mat_b_addr` in ADDR_W: B base byte address, 16-byte aligned
- `busy` out 1: high from the cycle after an accepted `start` until `done`
- `done` out 1: one-cycle pulse when the last pair is accepted
- `err` out 1: sticky error flag, cleared on accepted `start`
- `araddr` out ADDR_W: burst address
- `arlen` out 4: constant 3
- `arsize` out 3: constant 2
- `arburst` out 2: constant INCR (01)
- `arid` out 4: constant `ID`
- `arvalid` out 1: AR request valid
- `arready` in 1: AR request accepted
- `rdata` in DATA_W: read data
- `rresp` in 2: read response
- `rlast` in 1: last beat of the burst
- `rvalid` in 1: read data valid
- `rready` out 1: read data accept
- `a_col` out 4*DATA_W: A[0..3][k], with row r in bits [32r+31:32r]
- `b_row` out 4*DATA_W: B[k][0..3], with column c in bits [32c+31:32c]
- `pair_valid` out 1: `a_col`/`b_row` valid
- `pair_ready` in 1: MAC array accepts the pair
- `pair_last` out 1: high with `pair_valid` when k = width-1

## Operation
- FSM states: IDLE, REQ_A, DAT_A, REQ_B, DAT_B, OUT.
- **IDLE**
  - When `start` is high, capture `mat_width`, `mat_a_addr` and `mat_b_addr`, clear k and clear `err`.
  - If width = 0: pulse `done` next cycle, issue no bursts, stay in IDLE.
  - Otherwise go to REQ_A.
- `start` is ignored in any state other than IDLE.
- **REQ_A**
  - `arvalid` = 1 and `araddr` = a_base + 16*k.
  - On `arvalid` & `arready`, go to DAT_A.
- **DAT_A**
  - `rready` = 1.
  - Beat j (j = 0..3) is written into `a_col` slot j.
  - After beat 3, go to REQ_B.
- **REQ_B / DAT_B**
  - Same behaviour as REQ_A / DAT_A, with `araddr` = b_base + 16*k, filling `b_row` slot j.
  - After beat 3, go to OUT.
- **OUT**
  - `pair_valid` = 1.
  - On `pair_ready`: if k = width-1, pulse `done` and go to IDLE; otherwise k++ and go to REQ_A.
- **Error handling** (sets `err`, transfer continues unchanged)
  - `rresp` ≠ 00 on any beat.
  - `rlast` = 1 on beats 0–2.
  - `rlast` = 0 on beat 3.
- The beat counter counts beats only; the burst always ends after 4 beats regardless of `rlast`.
- Address arithmetic is modulo 2^ADDR_W, so wrap-around is silent.
- Only one burst is outstanding at a time. There is no overlap between OUT and the next fetch.

## Timing
- Reset values:
  - all outputs 0 except the constants `arlen`, `arsize`, `arburst`, `arid`
  - FSM in IDLE
  - `a_col` and `b_row` cleared
- Asserting `rst_n` mid-transfer aborts immediately: `arvalid`, `rready`, `pair_valid` and `busy` drop asynchronously. No `done` pulse is generated.
- Handshake rules:
  - `arvalid` and `araddr` are registered and held stable until `arready`.
  - `pair_valid`, `a_col` and `b_row` are held stable until `pair_ready`.
  - `pair_valid` never depends combinationally on `pair_ready`.
- Latency with `arready` and `rvalid` tied high and `pair_ready` high:
  - `start` → first `arvalid`: 1 cycle.
  - Per k: 12 cycles (1 AR + 4 R for A, 1 AR + 4 R for B, 1 OUT, plus 1 state-entry cycle for REQ_A).
  - `done` is asserted in the cycle after the final `pair_ready` handshake.
- If `pair_ready` is already high when OUT is entered, the pair is accepted in that first OUT cycle.
- `busy` is low in the same cycle that `done` is high.

## Test plan
- **Basic fetch.** Width=4, A=0x0, B=0x1000, zero-wait memory, `pair_ready` tied 1.
  - AR addresses: 0x0, 0x1000, 0x10, 0x1010, 0x20, 0x1020, 0x30, 0x1030.
  - 4 pairs are produced and match the memory contents, with `pair_last` on the 4th.
  - One `done` pulse follows.
- **Random stalls.** Width=16 with random `arready`, `rvalid` and `pair_ready` stalls (0–5 cycles).
  - Pairs are in order and bit-exact.
  - Outputs are stable while stalled.
  - Exactly 32 bursts are issued.
- **Zero width.** Width=0 with `start`.
  - No `arvalid` is ever asserted.
  - `done` pulses 1 cycle after `start`.
  - `busy` never goes high.
- **Start while busy.** Pulse `start` mid-transfer with different addresses.
  - The pulse is ignored; the transfer completes with the original addresses.
- **Bad response.** `rresp` = 10 on beat 2 of the k=1 B burst, and `rlast` early on the k=2 A burst.
  - `err` = 1 and stays set.
  - All width pairs are still delivered.
  - `err` clears on the next `start`.
- **Reset mid-run.** Assert reset during DAT_B of k=3.
  - All outputs return to reset values immediately.
  - After release, a new `start` with width=8 completes normally.
